// File: rtl/coin_pkg.sv
// rtl/coin_pkg.sv - shared state encoding and coin constants for the vending controller
package coin_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCUM  = 2'd1,
        VEND   = 2'd2,
        REFUND = 2'd3
    } state_t;

    localparam logic [11:0] COIN_100_VAL = 12'd100;
    localparam logic [11:0] COIN_500_VAL = 12'd500;
    localparam logic [11:0] MAX_AMT_DEF  = 12'd1500;

endpackage

// File: rtl/coin_vend_ctrl.sv
// rtl/coin_vend_ctrl.sv - coin credit accumulation, purchase and 100-unit refund sequencing
module coin_vend_ctrl
    import coin_pkg::*;
#(
    parameter logic [11:0] PRICE   = 12'd1000,
    parameter logic [11:0] MAX_AMT = MAX_AMT_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        coin_100,
    input  logic        coin_500,
    input  logic        buy,
    input  logic        cancel,
    output logic [11:0] cantidad,
    output logic        vend,
    output logic        refund_100,
    output logic        coin_reject,
    output logic        busy
);

    state_t      state, state_n;
    logic [11:0] credit_n;
    logic [11:0] coin_val;
    logic        coin_any, coin_fits;
    logic        vend_n, refund_n, reject_n, busy_n;

    always_comb begin
        state_n   = state;
        credit_n  = cantidad;
        vend_n    = 1'b0;
        refund_n  = 1'b0;
        reject_n  = 1'b0;
        coin_any  = coin_100 | coin_500;
        // coin_500 wins a simultaneous insertion; the 100 is turned away
        coin_val  = coin_500 ? COIN_500_VAL : (coin_100 ? COIN_100_VAL : 12'd0);
        coin_fits = (cantidad <= (MAX_AMT - coin_val));

        case (state)
            IDLE, ACCUM: begin
                if (state == ACCUM && cancel) begin
                    state_n  = REFUND;
                    credit_n = cantidad - COIN_100_VAL;
                    refund_n = 1'b1;
                    reject_n = coin_any;
                end else if (state == ACCUM && buy && cantidad >= PRICE) begin
                    state_n  = VEND;
                    credit_n = cantidad - PRICE;
                    vend_n   = 1'b1;
                    reject_n = coin_any;
                end else if (coin_any) begin
                    if (coin_fits) begin
                        credit_n = cantidad + coin_val;
                        state_n  = ACCUM;
                    end
                    reject_n = !coin_fits || (coin_500 && coin_100);
                end
            end
            VEND: begin
                reject_n = coin_any;
                if (cantidad >= COIN_100_VAL) begin
                    state_n  = REFUND;
                    credit_n = cantidad - COIN_100_VAL;
                    refund_n = 1'b1;
                end else begin
                    state_n = IDLE;
                end
            end
            REFUND: begin
                reject_n = coin_any;
                // the previous refund_100 register doubles as the pulse/gap toggle
                if (cantidad == 12'd0) begin
                    state_n = IDLE;
                end else if (!refund_100 && cantidad >= COIN_100_VAL) begin
                    credit_n = cantidad - COIN_100_VAL;
                    refund_n = 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase

        busy_n = (state_n == VEND) || (state_n == REFUND);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            cantidad    <= 12'd0;
            vend        <= 1'b0;
            refund_100  <= 1'b0;
            coin_reject <= 1'b0;
            busy        <= 1'b0;
        end else begin
            state       <= state_n;
            cantidad    <= credit_n;
            vend        <= vend_n;
            refund_100  <= refund_n;
            coin_reject <= reject_n;
            busy        <= busy_n;
        end
    end

endmodule

// File: tb/tb_coin_vend_ctrl.sv
// tb/tb_coin_vend_ctrl.sv - directed self-checking bench for coin_vend_ctrl
module tb_coin_vend_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        coin_100 = 1'b0, coin_500 = 1'b0, buy = 1'b0, cancel = 1'b0;
    logic [11:0] cantidad;
    logic        vend, refund_100, coin_reject, busy;

    int passed = 0;
    int total  = 0;

    coin_vend_ctrl dut (
        .clk(clk), .rst(rst), .coin_100(coin_100), .coin_500(coin_500),
        .buy(buy), .cancel(cancel), .cantidad(cantidad), .vend(vend),
        .refund_100(refund_100), .coin_reject(coin_reject), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        coin_100 = 0; coin_500 = 0; buy = 0; cancel = 0;
        rst = 1'b1;
        step();
        @(negedge clk);
        rst = 1'b0;
        step();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        total++; if (cantidad !== 12'd0) $display("FAIL reset_cantidad got %0d want 0", cantidad); else passed++;
        total++; if ({vend, refund_100, coin_reject, busy} !== 4'b0000)
            $display("FAIL reset_flags got %b want 0000", {vend, refund_100, coin_reject, busy}); else passed++;
        @(negedge clk);
        rst = 1'b0;
        step();
    endtask

    task automatic test_accumulation();
        coin_500 = 1; step(); coin_500 = 0;
        total++; if (cantidad !== 12'd500) $display("FAIL acc_500 got %0d want 500", cantidad); else passed++;
        coin_500 = 1; step(); coin_500 = 0;
        total++; if (cantidad !== 12'd1000) $display("FAIL acc_1000 got %0d want 1000", cantidad); else passed++;
        coin_100 = 1; step(); coin_100 = 0;
        total++; if (cantidad !== 12'd1100) $display("FAIL acc_1100 got %0d want 1100", cantidad); else passed++;
        total++; if ({coin_reject, busy} !== 2'b00) $display("FAIL acc_flags got %b want 00", {coin_reject, busy}); else passed++;
    endtask

    task automatic test_purchase();
        buy = 1; step(); buy = 0;
        total++; if ({vend, busy, refund_100} !== 3'b110) $display("FAIL buy_vend got %b want 110", {vend, busy, refund_100}); else passed++;
        total++; if (cantidad !== 12'd100) $display("FAIL buy_remainder got %0d want 100", cantidad); else passed++;
        step();
        total++; if ({vend, busy, refund_100} !== 3'b011) $display("FAIL buy_change got %b want 011", {vend, busy, refund_100}); else passed++;
        total++; if (cantidad !== 12'd0) $display("FAIL buy_change_amt got %0d want 0", cantidad); else passed++;
        step();
        total++; if ({vend, busy, refund_100} !== 3'b000) $display("FAIL buy_idle got %b want 000", {vend, busy, refund_100}); else passed++;
    endtask

    task automatic test_ceiling();
        do_reset();
        repeat (3) begin coin_500 = 1; step(); coin_500 = 0; end
        total++; if (cantidad !== 12'd1500) $display("FAIL ceil_fill got %0d want 1500", cantidad); else passed++;
        coin_100 = 1; step(); coin_100 = 0;
        total++; if ({coin_reject, cantidad} !== {1'b1, 12'd1500})
            $display("FAIL ceil_reject got rej=%b amt=%0d want rej=1 amt=1500", coin_reject, cantidad); else passed++;
        step();
        total++; if (coin_reject !== 1'b0) $display("FAIL ceil_reject_one_cycle got %b want 0", coin_reject); else passed++;
        do_reset();
        coin_100 = 1; coin_500 = 1; step(); coin_100 = 0; coin_500 = 0;
        total++; if ({coin_reject, cantidad} !== {1'b1, 12'd500})
            $display("FAIL dual_coin got rej=%b amt=%0d want rej=1 amt=500", coin_reject, cantidad); else passed++;
    endtask

    task automatic test_priority();
        do_reset();
        coin_500 = 1; step(); coin_500 = 0;
        buy = 1; coin_500 = 1; step(); buy = 0; coin_500 = 0;
        total++; if ({vend, coin_reject, cantidad} !== {2'b00, 12'd1000})
            $display("FAIL weak_buy_coin got v=%b rej=%b amt=%0d want v=0 rej=0 amt=1000", vend, coin_reject, cantidad); else passed++;
        buy = 1; coin_100 = 1; step(); buy = 0; coin_100 = 0;
        total++; if ({vend, coin_reject, cantidad} !== {2'b11, 12'd0})
            $display("FAIL exact_buy got v=%b rej=%b amt=%0d want v=1 rej=1 amt=0", vend, coin_reject, cantidad); else passed++;
        step();
        total++; if ({busy, refund_100} !== 2'b00) $display("FAIL exact_no_change got %b want 00", {busy, refund_100}); else passed++;
    endtask

    task automatic test_insufficient_cancel();
        int bad;
        do_reset();
        coin_500 = 1; step(); coin_500 = 0;
        coin_100 = 1; step(); coin_100 = 0;
        coin_100 = 1; step(); coin_100 = 0;
        buy = 1; step(); buy = 0;
        total++; if ({vend, busy, cantidad} !== {2'b00, 12'd700})
            $display("FAIL short_buy got v=%b b=%b amt=%0d want 0 0 700", vend, busy, cantidad); else passed++;
        cancel = 1; step(); cancel = 0;
        bad = 0;
        for (int i = 0; i < 7; i++) begin
            if (refund_100 !== 1'b1 || busy !== 1'b1 || cantidad !== 12'(600 - 100 * i)) begin
                $display("FAIL refund_pulse_%0d got r=%b amt=%0d want r=1 amt=%0d", i, refund_100, cantidad, 600 - 100 * i);
                bad++;
            end
            if (i < 6) begin
                if (i == 3) coin_500 = 1;
                step();
                coin_500 = 0;
                if (refund_100 !== 1'b0) begin
                    $display("FAIL refund_gap_%0d got r=%b want 0", i, refund_100);
                    bad++;
                end
                if (i == 3) begin
                    total++; if ({coin_reject, cantidad} !== {1'b1, 12'd300})
                        $display("FAIL refund_coin_reject got rej=%b amt=%0d want rej=1 amt=300", coin_reject, cantidad); else passed++;
                end
                step();
            end
        end
        total++; if (bad == 0) passed++;
        step();
        total++; if ({busy, refund_100, cantidad} !== {2'b00, 12'd0})
            $display("FAIL refund_done got b=%b r=%b amt=%0d want 0 0 0", busy, refund_100, cantidad); else passed++;
    endtask

    task automatic test_async_reset();
        int extra;
        do_reset();
        coin_500 = 1; step(); coin_500 = 0;
        cancel = 1; step(); cancel = 0;
        step(); step();
        total++; if ({refund_100, cantidad} !== {1'b1, 12'd300})
            $display("FAIL pre_reset got r=%b amt=%0d want r=1 amt=300", refund_100, cantidad); else passed++;
        #2 rst = 1'b1;
        #1;
        total++; if ({busy, refund_100, cantidad} !== {2'b00, 12'd0})
            $display("FAIL async_reset got b=%b r=%b amt=%0d want 0 0 0", busy, refund_100, cantidad); else passed++;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        extra = 0;
        repeat (6) begin
            step();
            if (refund_100 !== 1'b0) extra++;
        end
        total++; if (extra != 0) $display("FAIL post_reset_refunds got %0d want 0", extra); else passed++;
        coin_100 = 1; step(); coin_100 = 0;
        total++; if (cantidad !== 12'd100) $display("FAIL post_reset_coin got %0d want 100", cantidad); else passed++;
    endtask

    initial begin
        test_reset();
        test_accumulation();
        test_purchase();
        test_ceiling();
        test_priority();
        test_insufficient_cancel();
        test_async_reset();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
